dmem_stage: RTL and testbench
=============================

DMEM_STAGE -- requirements
Module: dmem_stage

Parameters
REQ-001 DATA_W, default 16, data path width in bits.
REQ-002 ADDR_W, default 16, address width in bits.
REQ-003 TIMEOUT, default 31, maximum cycles spent in WAIT before an error is flagged; must be 1..2^8-1.
REQ-004 CNT_W, default 16, width of the hit and miss statistic counters.
REQ-005 ALIGN_CHK, default 1; 1 enables odd-address error detection, 0 disables it.

Interface
REQ-006 clk  in  1  single clock; all state is updated on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en, wr, dump  in  1 each  pipeline memory enable, write select and dump request.
REQ-009 addr  in  ADDR_W  access address; wdata  in  DATA_W  store data.
REQ-010 rdata  out  DATA_W  load data; stall  out  1  pipeline hold; err  out  1  access error pulse.
REQ-011 m_rd, m_wr, m_dump  out  1 each  backing-memory request strobes.
REQ-012 m_addr  out  ADDR_W  and m_wdata  out  DATA_W  backing-memory address and data.
REQ-013 m_rdata  in  DATA_W, m_done  in  1, m_hit  in  1, m_err  in  1  backing-memory response.
REQ-014 hit_cnt, miss_cnt  out  CNT_W each  access statistics.

Function
REQ-015 The FSM shall have three states: IDLE, WAIT and RESP.
REQ-016 Misaligned access (ALIGN_CHK=1, en=1, addr[0]=1) in IDLE: err=1 for that cycle, no strobe, stall=0, state remains IDLE.
REQ-017 Aligned access in IDLE (en=1): assert m_rd=~wr or m_wr=wr for exactly that cycle, with m_addr=addr and m_wdata=wdata.
REQ-018 IDLE issue with m_done=1 in the same cycle:
- stall=0 and rdata=m_rdata, combinationally;
- rdata_q captures m_rdata;
- state remains IDLE.
REQ-019 IDLE issue with m_done=0:
- stall=1;
- addr, wdata and wr are latched;
- the timeout counter is cleared;
- next state is WAIT.
REQ-020 In WAIT:
- m_rd=m_wr=0 (request is a pulse only);
- m_addr and m_wdata are driven from the latched values;
- stall=1.
REQ-021 In WAIT with m_done=1: capture m_rdata into rdata_q; next state is RESP.
REQ-022 In WAIT with m_err=1 (takes priority over m_done), or when the timeout counter reaches TIMEOUT:
- err=1 for one cycle;
- stall=0 that cycle;
- next state is IDLE;
- rdata_q is unchanged.
REQ-023 In RESP:
- stall=0, rdata=rdata_q;
- en is ignored, so the held instruction is not reissued;
- next state is IDLE.
REQ-024 rdata shall equal rdata_q whenever REQ-018 does not apply.
REQ-025 m_dump shall equal dump & (state==IDLE) and is independent of en.
REQ-026 In IDLE with en=0, all strobes are 0 and stall=0.
REQ-027 hit_cnt shall increment when an IDLE-issued access sees m_done=1 and m_hit=1 in the same cycle.
REQ-028 miss_cnt shall increment on each WAIT->RESP transition.
REQ-029 hit_cnt and miss_cnt shall saturate at all-ones.
REQ-030 Error completions (REQ-016, REQ-022) shall increment neither counter.
REQ-031 m_err in IDLE on an issue cycle shall behave as in REQ-022 (err=1, stall=0, state remains IDLE), and m_done is ignored that cycle.

Reset
REQ-032 With rst=1 at a clock edge, the following shall hold after that edge:
- state=IDLE;
- rdata_q=0, hit_cnt=0, miss_cnt=0;
- the timeout counter and latched request registers are 0.
REQ-033 While rst=1, all outputs shall be 0 (stall, err, m_rd, m_wr, m_dump, rdata, m_addr, m_wdata), regardless of en.
REQ-034 Reset asserted in WAIT or RESP shall abandon the access: no counter update, no err.

Verification
REQ-035 Hit load: en=1, wr=0, addr=0x0010, m_done=1, m_hit=1, m_rdata=0xBEEF.
- Expected: m_rd pulses for 1 cycle, stall=0, rdata=0xBEEF, hit_cnt=1.
REQ-036 Miss store: en=1, wr=1, addr=0x0020, wdata=0x1234; m_done arrives 4 cycles later.
- Expected: m_wr pulses once, stall=1 for 4 cycles, m_addr holds 0x0020, then 1 RESP cycle with stall=0, miss_cnt=1.
REQ-037 Misaligned access: addr=0x0011, en=1.
- Expected: err=1 for 1 cycle, m_rd=m_wr=0, stall=0, counters unchanged.
REQ-038 Timeout: TIMEOUT=3, miss with m_done never asserted.
- Expected: stall=1 for 3 cycles, then err=1 with stall=0, back to IDLE, rdata_q unchanged.
REQ-039 Reset mid-WAIT: issue a miss, assert rst on the 2nd WAIT cycle.
- Expected: next cycle IDLE, stall=0, miss_cnt=0, and a late m_done is ignored.
REQ-040 Counter saturation: CNT_W=2, 5 consecutive hits.
- Expected: hit_cnt=3.

Source files
------------

// File: rtl/dmem_stage.sv
// Data-memory pipeline stage: issues single-cycle requests to a backing
// memory, holds the pipeline while a miss is outstanding, flags misaligned
// accesses, memory errors and timeouts, and keeps saturating hit/miss counts.
module dmem_stage #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 31,
    parameter int CNT_W     = 16,
    parameter int ALIGN_CHK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic              dump,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    output logic              m_rd,
    output logic              m_wr,
    output logic              m_dump,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_done,
    input  logic              m_hit,
    input  logic              m_err,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        tcnt_q;
    logic [7:0]        tcnt_inc;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic misalign;
    logic issue;
    logic timeout;
    logic idle_done;
    logic wait_done;
    logic go_wait;

    // Decode the events that drive both the FSM and the datapath registers.
    // The timeout fires when the incremented count reaches TIMEOUT, so the
    // issue cycle plus WAIT cycles stall for exactly TIMEOUT cycles.
    always_comb begin
        misalign  = (ALIGN_CHK != 0) && addr[0];
        issue     = (state_q == IDLE) && en && !misalign;
        tcnt_inc  = tcnt_q + 8'd1;
        timeout   = (tcnt_inc == 8'(TIMEOUT));
        idle_done = issue && !m_err && m_done;
        go_wait   = issue && !m_err && !m_done;
        wait_done = (state_q == WAIT) && !m_err && m_done;
    end

    // Next-state and output logic; reset forces every output low.
    always_comb begin
        state_d = state_q;
        rdata   = rdata_q;
        stall   = 1'b0;
        err     = 1'b0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_dump  = 1'b0;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                m_addr  = addr;
                m_wdata = wdata;
                m_dump  = dump;
                if (en) begin
                    if (misalign) begin
                        err = 1'b1;
                    end else begin
                        m_rd = !wr;
                        m_wr = wr;
                        if (m_err) begin
                            err = 1'b1;
                        end else if (m_done) begin
                            rdata = m_rdata;
                        end else begin
                            stall   = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (m_err) begin
                    err     = 1'b1;
                    stall   = 1'b0;
                    state_d = IDLE;
                end else if (m_done) begin
                    state_d = RESP;
                end else if (timeout) begin
                    err     = 1'b1;
                    stall   = 1'b0;
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            state_d = IDLE;
            rdata   = '0;
            stall   = 1'b0;
            err     = 1'b0;
            m_rd    = 1'b0;
            m_wr    = 1'b0;
            m_dump  = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
        end
    end

    // State, request latches, timeout counter, read data and statistics.
    // The write flag is not latched: strobes are single-cycle pulses and
    // nothing after the issue cycle depends on the access direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (go_wait) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                tcnt_q  <= '0;
            end else if (state_q == WAIT) begin
                tcnt_q <= tcnt_inc;
            end
            if (idle_done || wait_done) begin
                rdata_q <= m_rdata;
            end
            if (idle_done && m_hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (wait_done && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// Directed self-checking bench for dmem_stage (TIMEOUT=3, CNT_W=2).
module tb_dmem_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        wr;
    logic        dump;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        stall;
    logic        err;
    logic        m_rd;
    logic        m_wr;
    logic        m_dump;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_done;
    logic        m_hit;
    logic        m_err;
    logic [1:0]  hit_cnt;
    logic [1:0]  miss_cnt;

    int passed;
    int total;

    dmem_stage #(
        .DATA_W(16),
        .ADDR_W(16),
        .TIMEOUT(3),
        .CNT_W(2),
        .ALIGN_CHK(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .dump(dump),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
        .m_rd(m_rd), .m_wr(m_wr), .m_dump(m_dump), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done), .m_hit(m_hit),
        .m_err(m_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        en = 0; wr = 0; dump = 0; addr = '0; wdata = '0;
        m_rdata = '0; m_done = 0; m_hit = 0; m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; wr = 0; addr = 16'h0010; wdata = 16'h9999; dump = 1;
        @(negedge clk);
        total++; if (stall !== 1'b0) $display("FAIL rst_stall got %0d exp 0", stall); else passed++;
        total++; if (m_rd !== 1'b0) $display("FAIL rst_m_rd got %0d exp 0", m_rd); else passed++;
        total++; if (m_dump !== 1'b0) $display("FAIL rst_m_dump got %0d exp 0", m_dump); else passed++;
        total++; if (m_addr !== 16'h0000) $display("FAIL rst_m_addr got %h exp 0000", m_addr); else passed++;
        total++; if (m_wdata !== 16'h0000) $display("FAIL rst_m_wdata got %h exp 0000", m_wdata); else passed++;
        total++; if (rdata !== 16'h0000) $display("FAIL rst_rdata got %h exp 0000", rdata); else passed++;
        tick();
        total++; if (hit_cnt !== 2'd0 || miss_cnt !== 2'd0) $display("FAIL rst_cnt got %0d/%0d exp 0/0", hit_cnt, miss_cnt); else passed++;
        rst = 0; quiet();
        tick();
    endtask

    task automatic test_hit_load();
        en = 1; wr = 0; addr = 16'h0010; m_done = 1; m_hit = 1; m_rdata = 16'hBEEF;
        @(negedge clk);
        total++; if (m_rd !== 1'b1 || m_wr !== 1'b0) $display("FAIL hit_strobe got rd=%0d wr=%0d exp 1/0", m_rd, m_wr); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL hit_stall got %0d exp 0", stall); else passed++;
        total++; if (rdata !== 16'hBEEF) $display("FAIL hit_rdata got %h exp beef", rdata); else passed++;
        total++; if (m_addr !== 16'h0010) $display("FAIL hit_m_addr got %h exp 0010", m_addr); else passed++;
        tick();
        quiet();
        @(negedge clk);
        total++; if (hit_cnt !== 2'd1) $display("FAIL hit_cnt got %0d exp 1", hit_cnt); else passed++;
        total++; if (m_rd !== 1'b0) $display("FAIL hit_pulse got %0d exp 0", m_rd); else passed++;
        total++; if (rdata !== 16'hBEEF) $display("FAIL hit_rdata_q got %h exp beef", rdata); else passed++;
        tick();
    endtask

    task automatic test_miss_store();
        en = 1; wr = 1; addr = 16'h0020; wdata = 16'h1234;
        @(negedge clk);
        total++; if (m_wr !== 1'b1 || m_rd !== 1'b0) $display("FAIL miss_strobe got wr=%0d rd=%0d exp 1/0", m_wr, m_rd); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL miss_stall0 got %0d exp 1", stall); else passed++;
        total++; if (m_wdata !== 16'h1234) $display("FAIL miss_m_wdata got %h exp 1234", m_wdata); else passed++;
        tick();
        quiet();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (stall !== 1'b1 || m_wr !== 1'b0) $display("FAIL miss_wait%0d got stall=%0d wr=%0d exp 1/0", i, stall, m_wr); else passed++;
            total++; if (m_addr !== 16'h0020 || m_wdata !== 16'h1234) $display("FAIL miss_hold%0d got %h/%h exp 0020/1234", i, m_addr, m_wdata); else passed++;
            tick();
        end
        // completion lands on the same cycle the timeout would fire
        m_done = 1; m_rdata = 16'h5A5A;
        @(negedge clk);
        total++; if (stall !== 1'b1 || err !== 1'b0) $display("FAIL miss_done got stall=%0d err=%0d exp 1/0", stall, err); else passed++;
        tick();
        quiet();
        en = 1; addr = 16'h0030;
        @(negedge clk);
        total++; if (stall !== 1'b0 || m_rd !== 1'b0 || m_wr !== 1'b0) $display("FAIL resp_out got stall=%0d rd=%0d wr=%0d exp 0/0/0", stall, m_rd, m_wr); else passed++;
        total++; if (rdata !== 16'h5A5A) $display("FAIL resp_rdata got %h exp 5a5a", rdata); else passed++;
        tick();
        quiet();
        @(negedge clk);
        total++; if (miss_cnt !== 2'd1 || hit_cnt !== 2'd1) $display("FAIL miss_cnt got %0d/%0d exp 1/1", miss_cnt, hit_cnt); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL miss_idle got %0d exp 0", stall); else passed++;
        tick();
    endtask

    task automatic test_misaligned();
        en = 1; wr = 0; addr = 16'h0011; m_done = 1; m_hit = 1; m_rdata = 16'hFFFF;
        @(negedge clk);
        total++; if (err !== 1'b1) $display("FAIL mis_err got %0d exp 1", err); else passed++;
        total++; if (m_rd !== 1'b0 || m_wr !== 1'b0 || stall !== 1'b0) $display("FAIL mis_out got rd=%0d wr=%0d stall=%0d exp 0/0/0", m_rd, m_wr, stall); else passed++;
        tick();
        quiet();
        @(negedge clk);
        total++; if (err !== 1'b0) $display("FAIL mis_pulse got %0d exp 0", err); else passed++;
        total++; if (hit_cnt !== 2'd1 || miss_cnt !== 2'd1) $display("FAIL mis_cnt got %0d/%0d exp 1/1", hit_cnt, miss_cnt); else passed++;
        total++; if (rdata !== 16'h5A5A) $display("FAIL mis_rdata got %h exp 5a5a", rdata); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        en = 1; wr = 0; addr = 16'h0040;
        @(negedge clk);
        total++; if (stall !== 1'b1 || m_rd !== 1'b1) $display("FAIL to_issue got stall=%0d rd=%0d exp 1/1", stall, m_rd); else passed++;
        tick();
        quiet();
        @(negedge clk);
        total++; if (stall !== 1'b1 || err !== 1'b0) $display("FAIL to_wait1 got stall=%0d err=%0d exp 1/0", stall, err); else passed++;
        tick();
        @(negedge clk);
        total++; if (stall !== 1'b1 || err !== 1'b0) $display("FAIL to_wait2 got stall=%0d err=%0d exp 1/0", stall, err); else passed++;
        tick();
        @(negedge clk);
        total++; if (stall !== 1'b0 || err !== 1'b1) $display("FAIL to_fire got stall=%0d err=%0d exp 0/1", stall, err); else passed++;
        tick();
        @(negedge clk);
        total++; if (err !== 1'b0 || stall !== 1'b0) $display("FAIL to_idle got err=%0d stall=%0d exp 0/0", err, stall); else passed++;
        total++; if (rdata !== 16'h5A5A) $display("FAIL to_rdata got %h exp 5a5a", rdata); else passed++;
        total++; if (miss_cnt !== 2'd1) $display("FAIL to_miss_cnt got %0d exp 1", miss_cnt); else passed++;
        // back in IDLE: a completing access without m_hit counts nothing
        en = 1; addr = 16'h0042; m_done = 1; m_hit = 0; m_rdata = 16'h7777;
        @(negedge clk);
        total++; if (rdata !== 16'h7777 || stall !== 1'b0) $display("FAIL to_after got %h/%0d exp 7777/0", rdata, stall); else passed++;
        tick();
        quiet();
        @(negedge clk);
        total++; if (hit_cnt !== 2'd1) $display("FAIL to_nohit got %0d exp 1", hit_cnt); else passed++;
        tick();
    endtask

    task automatic test_m_err_idle();
        en = 1; wr = 0; addr = 16'h0050; m_done = 1; m_hit = 1; m_err = 1; m_rdata = 16'hAAAA;
        @(negedge clk);
        total++; if (err !== 1'b1 || stall !== 1'b0) $display("FAIL merr_out got err=%0d stall=%0d exp 1/0", err, stall); else passed++;
        total++; if (rdata !== 16'h7777) $display("FAIL merr_rdata got %h exp 7777", rdata); else passed++;
        tick();
        quiet();
        @(negedge clk);
        total++; if (hit_cnt !== 2'd1 || rdata !== 16'h7777) $display("FAIL merr_after got %0d/%h exp 1/7777", hit_cnt, rdata); else passed++;
        total++; if (stall !== 1'b0 || err !== 1'b0) $display("FAIL merr_idle got stall=%0d err=%0d exp 0/0", stall, err); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        en = 1; wr = 0; addr = 16'h0060;
        tick();
        quiet();
        tick();
        rst = 1;
        @(negedge clk);
        total++; if (stall !== 1'b0 || err !== 1'b0 || m_addr !== 16'h0000) $display("FAIL rw_out got stall=%0d err=%0d addr=%h exp 0/0/0000", stall, err, m_addr); else passed++;
        tick();
        rst = 0; m_done = 1; m_rdata = 16'h1111;
        @(negedge clk);
        total++; if (stall !== 1'b0 || err !== 1'b0) $display("FAIL rw_idle got stall=%0d err=%0d exp 0/0", stall, err); else passed++;
        total++; if (rdata !== 16'h0000) $display("FAIL rw_rdata got %h exp 0000", rdata); else passed++;
        tick();
        quiet();
        @(negedge clk);
        total++; if (miss_cnt !== 2'd0 || hit_cnt !== 2'd0) $display("FAIL rw_cnt got %0d/%0d exp 0/0", miss_cnt, hit_cnt); else passed++;
        total++; if (rdata !== 16'h0000) $display("FAIL rw_late got %h exp 0000", rdata); else passed++;
        tick();
    endtask

    task automatic test_dump();
        dump = 1; en = 1; wr = 0; addr = 16'h0070;
        @(negedge clk);
        total++; if (m_dump !== 1'b1) $display("FAIL dump_idle got %0d exp 1", m_dump); else passed++;
        tick();
        en = 0;
        @(negedge clk);
        total++; if (m_dump !== 1'b0 || stall !== 1'b1) $display("FAIL dump_wait got %0d/%0d exp 0/1", m_dump, stall); else passed++;
        m_done = 1; m_rdata = 16'h2222;
        tick();
        m_done = 0;
        @(negedge clk);
        total++; if (m_dump !== 1'b0 || rdata !== 16'h2222) $display("FAIL dump_resp got %0d/%h exp 0/2222", m_dump, rdata); else passed++;
        tick();
        @(negedge clk);
        total++; if (m_dump !== 1'b1 || miss_cnt !== 2'd1) $display("FAIL dump_back got %0d/%0d exp 1/1", m_dump, miss_cnt); else passed++;
        tick();
        quiet();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_hits;
        for (int i = 0; i < 5; i++) begin
            en = 1; wr = 0; addr = 16'(16'h0100 + 2 * i); m_done = 1; m_hit = 1;
            m_rdata = 16'(16'hC000 + i);
            @(negedge clk);
            total++; if (rdata !== 16'(16'hC000 + i) || stall !== 1'b0) $display("FAIL b2b_rd%0d got %h/%0d exp %h/0", i, rdata, stall, 16'(16'hC000 + i)); else passed++;
            tick();
            exp_hits = (i >= 2) ? 2'd3 : 2'(i + 1);
            total++; if (hit_cnt !== exp_hits) $display("FAIL b2b_hit%0d got %0d exp %0d", i, hit_cnt, exp_hits); else passed++;
        end
        quiet();
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1;
        quiet();
        tick();
        test_reset();
        test_hit_load();
        test_miss_store();
        test_misaligned();
        test_timeout();
        test_m_err_idle();
        test_reset_mid_wait();
        test_dump();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
